// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU sequencer: FSM state encoding and captured instruction record.
package alu_seq_pkg;

    localparam int ALU_SEQ_DATA_W = 4;
    localparam int ALU_SEQ_OP_W   = 4;
    // Index fields are sized for the largest supported register file (8 entries).
    localparam int ALU_SEQ_IDX_W  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } alu_seq_state_t;

    typedef struct packed {
        logic [ALU_SEQ_OP_W-1:0]   op;
        logic [ALU_SEQ_IDX_W-1:0]  rd;
        logic [ALU_SEQ_IDX_W-1:0]  rs;
        logic                      imm_sel;
        logic [ALU_SEQ_DATA_W-1:0] imm;
    } alu_seq_instr_t;

    function automatic logic is_zero(input logic [ALU_SEQ_DATA_W-1:0] value);
        return (value == {ALU_SEQ_DATA_W{1'b0}});
    endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// Operand register file: one synchronous write port, two operand reads and a debug read,
// all reads combinational.
module alu_seq_regfile
    import alu_seq_pkg::*;
#(
    parameter int DATA_W    = ALU_SEQ_DATA_W,
    parameter int NUM_REGS  = 4,
    parameter int REG_IDX_W = $clog2(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [REG_IDX_W-1:0] waddr,
    input  logic [DATA_W-1:0]    wdata,
    input  logic [REG_IDX_W-1:0] raddr_a,
    output logic [DATA_W-1:0]    rdata_a,
    input  logic [REG_IDX_W-1:0] raddr_b,
    output logic [DATA_W-1:0]    rdata_b,
    input  logic [REG_IDX_W-1:0] dbg_sel,
    output logic [DATA_W-1:0]    dbg_data
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    // Next register contents: single write port.
    always_comb begin
        regs_d = regs_q;
        if (we) begin
            regs_d[waddr] = wdata;
        end else begin
            regs_d = regs_q;
        end
    end

    // Register storage, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= {DATA_W{1'b0}};
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rdata_a  = regs_q[raddr_a];
    assign rdata_b  = regs_q[raddr_b];
    assign dbg_data = regs_q[dbg_sel];

endmodule

// File: rtl/alu_sequencer.sv
// Four-state sequencer driving an external ALU: capture, operand read, execute, writeback.
// Optional ALU_SEQ_STICKY_OVF_EN makes flagOvf sticky and adds the ovfClr input.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DATA_W    = ALU_SEQ_DATA_W,
    parameter int NUM_REGS  = 4,
    parameter int REG_IDX_W = $clog2(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic                 instrValid,
    output logic                 instrReady,
    input  logic [3:0]           instrOp,
    input  logic [REG_IDX_W-1:0] instrRd,
    input  logic [REG_IDX_W-1:0] instrRs,
    input  logic                 instrImmSel,
    input  logic [DATA_W-1:0]    instrImm,
    output logic [3:0]           aluOpCode,
    output logic [DATA_W-1:0]    aluA,
    output logic [DATA_W-1:0]    aluB,
    input  logic [DATA_W-1:0]    aluResult,
    input  logic                 aluOverFlow,
    output logic                 resultValid,
    output logic [DATA_W-1:0]    resultData,
    output logic                 flagZero,
    output logic                 flagOvf,
`ifdef ALU_SEQ_STICKY_OVF_EN
    input  logic                 ovfClr,
`endif
    input  logic [REG_IDX_W-1:0] dbgSel,
    output logic [DATA_W-1:0]    dbgData
);

    alu_seq_state_t    state_q, state_d;
    alu_seq_instr_t    instr_q, instr_d;
    logic [3:0]        alu_op_q, alu_op_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic              result_valid_q, result_valid_d;
    logic [DATA_W-1:0] result_data_q, result_data_d;
    logic              flag_zero_q, flag_zero_d;
    logic              flag_ovf_q, flag_ovf_d;
    logic              instr_ready_q, instr_ready_d;
    logic              wb_en_s;
    logic [DATA_W-1:0] rdata_a_s, rdata_b_s;
    logic              idx_unused_s;

    // Upper index bits exist only to fit the widest register file.
    assign idx_unused_s = ^{instr_q.rd, instr_q.rs};

    alu_seq_regfile #(
        .DATA_W    (DATA_W),
        .NUM_REGS  (NUM_REGS),
        .REG_IDX_W (REG_IDX_W)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rstN),
        .we       (wb_en_s),
        .waddr    (instr_q.rd[REG_IDX_W-1:0]),
        .wdata    (aluResult),
        .raddr_a  (instr_q.rd[REG_IDX_W-1:0]),
        .rdata_a  (rdata_a_s),
        .raddr_b  (instr_q.rs[REG_IDX_W-1:0]),
        .rdata_b  (rdata_b_s),
        .dbg_sel  (dbgSel),
        .dbg_data (dbgData)
    );

    // Next-state and datapath control for the capture/read/execute/writeback sequence.
    always_comb begin
        state_d        = state_q;
        instr_d        = instr_q;
        alu_op_d       = alu_op_q;
        alu_a_d        = alu_a_q;
        alu_b_d        = alu_b_q;
        result_valid_d = result_valid_q;
        result_data_d  = result_data_q;
        flag_zero_d    = flag_zero_q;
        wb_en_s        = 1'b0;
`ifdef ALU_SEQ_STICKY_OVF_EN
        flag_ovf_d     = ovfClr ? 1'b0 : flag_ovf_q;
`else
        flag_ovf_d     = flag_ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (instrValid) begin
                    instr_d.op      = instrOp;
                    instr_d.rd      = ALU_SEQ_IDX_W'(instrRd);
                    instr_d.rs      = ALU_SEQ_IDX_W'(instrRs);
                    instr_d.imm_sel = instrImmSel;
                    instr_d.imm     = ALU_SEQ_DATA_W'(instrImm);
                    state_d         = READ;
                end else begin
                    state_d = IDLE;
                end
            end
            READ: begin
                alu_op_d = instr_q.op;
                alu_a_d  = rdata_a_s;
                alu_b_d  = instr_q.imm_sel ? DATA_W'(instr_q.imm) : rdata_b_s;
                state_d  = EXEC;
            end
            EXEC: begin
                wb_en_s        = 1'b1;
                result_data_d  = aluResult;
                flag_zero_d    = is_zero(ALU_SEQ_DATA_W'(aluResult));
                result_valid_d = 1'b1;
`ifdef ALU_SEQ_STICKY_OVF_EN
                // A setting writeback overrides a same-cycle clear.
                flag_ovf_d     = aluOverFlow | flag_ovf_d;
`else
                flag_ovf_d     = aluOverFlow;
`endif
                state_d        = WB;
            end
            WB: begin
                result_valid_d = 1'b0;
                state_d        = IDLE;
            end
            default: begin
                result_valid_d = 1'b0;
                state_d        = IDLE;
            end
        endcase
        instr_ready_d = (state_d == IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q        <= IDLE;
            instr_q        <= '{default: '0};
            alu_op_q       <= 4'd0;
            alu_a_q        <= {DATA_W{1'b0}};
            alu_b_q        <= {DATA_W{1'b0}};
            result_valid_q <= 1'b0;
            result_data_q  <= {DATA_W{1'b0}};
            flag_zero_q    <= 1'b0;
            flag_ovf_q     <= 1'b0;
            instr_ready_q  <= 1'b1;
        end else begin
            state_q        <= state_d;
            instr_q        <= instr_d;
            alu_op_q       <= alu_op_d;
            alu_a_q        <= alu_a_d;
            alu_b_q        <= alu_b_d;
            result_valid_q <= result_valid_d;
            result_data_q  <= result_data_d;
            flag_zero_q    <= flag_zero_d;
            flag_ovf_q     <= flag_ovf_d;
            instr_ready_q  <= instr_ready_d;
        end
    end

    assign instrReady  = instr_ready_q;
    assign aluOpCode   = alu_op_q;
    assign aluA        = alu_a_q;
    assign aluB        = alu_b_q;
    assign resultValid = result_valid_q;
    assign resultData  = result_data_q;
    assign flagZero    = flag_zero_q;
    assign flagOvf     = flag_ovf_q;

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Multi-cycle control unit that sequences the 4-bit ALU for the CPU core. It accepts one instruction at a time over a valid/ready handshake and reads operands from a small internal register file. It drives the ALU's opcode and operand inputs, samples the ALU result and overflow, writes the result back and updates status flags. The ALU is instantiated beside this block; its ports connect through the alu* ports.

Parameters:
DATA_W, 4, operand/result width; must match the ALU.
NUM_REGS, 4, register-file depth; power of two, 2..8.
REG_IDX_W, $clog2(NUM_REGS), register index width; derived, not overridden.

Ports:
clk  input  1  system clock, rising edge
rstN  input  1  asynchronous active-low reset
instrValid  input  1  instruction present
instrReady  output  1  sequencer can accept an instruction
instrOp  input  4  ALU opcode, passed through unmodified
instrRd  input  REG_IDX_W  destination register, also source A
instrRs  input  REG_IDX_W  source B register
instrImmSel  input  1  1 = operand B is instrImm, 0 = reg[instrRs]
instrImm  input  DATA_W  immediate operand
aluOpCode  output  4  to ALU opCode
aluA  output  DATA_W  to ALU a
aluB  output  DATA_W  to ALU b
aluResult  input  DATA_W  from ALU aOut
aluOverFlow  input  1  from ALU overFlow
resultValid  output  1  one-cycle pulse at writeback
resultData  output  DATA_W  value written back
flagZero  output  1  last result == 0
flagOvf  output  1  overflow flag
dbgSel  input  REG_IDX_W  debug read index
dbgData  output  DATA_W  reg[dbgSel], combinational read

Behaviour:
- Reset (rstN low, asynchronous, also mid-instruction): state IDLE, all registers 0, captured instruction discarded. aluOpCode/aluA/aluB=0, resultValid=0, resultData=0, flagZero=0, flagOvf=0. instrReady=1 in the first cycle after release.
- FSM states: IDLE, READ, EXEC, WB.
- IDLE: instrReady=1. On instrValid&&instrReady at edge E0, capture op/rd/rs/immSel/imm and go to READ.
- READ: instrReady=0. At E1, load aluOpCode=op, aluA=reg[rd], aluB = immSel ? imm : reg[rs] (registered), then go to EXEC.
- EXEC: ALU settles combinationally. At E2, reg[rd]<=aluResult, resultData<=aluResult, flagZero<=(aluResult==0), flagOvf<=aluOverFlow, resultValid<=1, then go to WB.
- WB: resultValid=1 for exactly this cycle. At E3, go to IDLE and drop resultValid to 0.
- Latency: 3 edges from accept to writeback; throughput is one instruction per 4 cycles. There is no back-to-back accept.
- aluOpCode/aluA/aluB hold their values from READ onward until the next READ. They are stable for the whole of EXEC and WB.
- rd==rs is legal; both operands read the same pre-write value.
- instrValid while not ready: ignored. The source must hold it; the sequencer does not capture it.
- Instruction fields change while instrValid is low: no effect.
- dbgSel==rd during WB returns the new value, because the write happened at E2. During EXEC it returns the old value.
- Result arithmetic is entirely the ALU's. The sequencer never interprets the opcode, and no width extension occurs.

Optional Feature:
ALU_SEQ_STICKY_OVF_EN
- Defined: flagOvf is sticky. It is set at any writeback with aluOverFlow=1 and cleared only by reset or the added input port ovfClr (1 bit, synchronous). If ovfClr and a setting writeback occur in the same cycle, set wins.
- Undefined: flagOvf reflects only the most recent writeback, and the ovfClr port does not exist.

Decomposition:
- Package alu_seq_pkg:
  - state enum alu_seq_state_t {IDLE, READ, EXEC, WB}
  - packed struct alu_seq_instr_t {op, rd, rs, immSel, imm}
  - DATA_W default constant
- Sub-module alu_seq_regfile: NUM_REGS x DATA_W, async reset to 0, one synchronous write port, two combinational read ports for operands A/B, plus one combinational debug read port.

Test Plan:
- Reset values: hold rstN=0, then release. All outputs are 0 except instrReady=1, and dbgData=0 for every dbgSel.
- Immediate path: accept op=4'h3, rd=1, immSel=1, imm=4'h5. In EXEC, aluOpCode=3, aluA=0, aluB=5. Bench stub drives aluResult=4'hA, aluOverFlow=0. resultValid pulses exactly 3 edges after accept with resultData=4'hA, flagZero=0, and dbgData(sel=1)=4'hA.
- Register path / zero flag: after reg1=4'hA, accept rd=1, rs=1, immSel=0. Expect aluA=aluB=4'hA. Stub result 4'h0 with overflow 1 gives flagZero=1, flagOvf=1, reg1=0.
- Backpressure: hold instrValid=1 continuously with changing fields. instrReady is 0 for READ/EXEC/WB and only one capture occurs per 4 cycles. Instructions presented while not ready are not captured.
- Reset mid-operation: assert rstN=0 during EXEC. There is no resultValid pulse, the destination register stays at its pre-instruction reset value of 0, and the state is IDLE after release.
- Overflow persistence: overflow=1 followed by a non-overflow instruction. Without the macro, flagOvf returns to 0. With ALU_SEQ_STICKY_OVF_EN, it stays 1 until an ovfClr pulse; ovfClr asserted in the same cycle as an overflow writeback leaves flagOvf=1.
